// File: rtl/dff_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dff_ctrl_pkg
//  Description : Shared types and default parameter values for the shared
//                D-flip-flop write arbiter and its helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package dff_ctrl_pkg;

    localparam int unsigned C_N_REQ_DEFAULT    = 4;
    localparam int unsigned C_WIDTH_DEFAULT    = 8;
    localparam int unsigned C_MAX_HOLD_DEFAULT = 4;

    // Arbiter FSM: waiting for a request, or serving one owner's tenure
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dff_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dff_write_arbiter_if
//  Description : Request/data/grant bundle between the producers and the
//                shared-register write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dff_write_arbiter_if
    import dff_ctrl_pkg::*;
#(
    parameter int N_REQ = C_N_REQ_DEFAULT,
    parameter int WIDTH = C_WIDTH_DEFAULT
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic                   busy;

    // Producer side: drives requests and data, observes grant and register
    modport master (
        output req, wdata,
        input  gnt, q, q_valid, busy
    );

    // Arbiter side
    modport slave (
        input  req, wdata,
        output gnt, q, q_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Scans req circularly
//                starting at ptr and returns the first set bit as a one-hot
//                vector and as an index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import dff_ctrl_pkg::*;
#(
    parameter int N_REQ = C_N_REQ_DEFAULT,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [PTR_W-1:0] ptr,
    output logic      [N_REQ-1:0] onehot,
    output logic      [PTR_W-1:0] idx,
    output logic                  any
);

    int               w_sum;
    logic [PTR_W-1:0] w_j;

    // First requester at or after ptr, wrapping modulo N_REQ
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        w_sum  = 0;
        w_j    = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_sum = int'(ptr) + off;
            if (w_sum >= N_REQ) begin
                w_sum = w_sum - N_REQ;
            end
            w_j = PTR_W'(w_sum);
            if (!any && req[w_j]) begin
                any         = 1'b1;
                onehot[w_j] = 1'b1;
                idx         = w_j;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dff_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dff_write_arbiter
//  Description : Round-robin arbiter granting one requester a bounded write
//                tenure over a shared WIDTH-bit register. Each granted cycle
//                with the owner still requesting loads its data into q and
//                pulses q_valid. Every tenure is followed by an idle cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_write_arbiter
    import dff_ctrl_pkg::*;
#(
    parameter int N_REQ    = C_N_REQ_DEFAULT,
    parameter int WIDTH    = C_WIDTH_DEFAULT,
    parameter int MAX_HOLD = C_MAX_HOLD_DEFAULT
) (
    input wire logic           clk,
    input wire logic           reset,
    dff_write_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_t       r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [N_REQ-1:0] r_gnt;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_busy;

    logic [N_REQ-1:0] w_pick_onehot;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic [WIDTH-1:0] w_wdata_arr [N_REQ];
    logic             w_owner_req;
    logic [WIDTH-1:0] w_owner_data;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_last;
    logic [PTR_W-1:0] w_ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_wdata_arr[gi] = bus.wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (r_ptr),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    // Only the current owner's request and data are ever looked at in GRANT
    assign w_owner_req  = bus.req[r_owner];
    assign w_owner_data = w_wdata_arr[r_owner];
    assign w_cnt_next   = r_cnt + CNT_W'(1);
    assign w_last       = (w_cnt_next == CNT_W'(MAX_HOLD));
    assign w_ptr_next   = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

    // Arbitration FSM with registered grant, register and strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_q_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_gnt   <= w_pick_onehot;
                        r_owner <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_owner_req) begin
                        r_q       <= w_owner_data;
                        r_q_valid <= 1'b1;
                        r_cnt     <= w_cnt_next;
                    end
                    // Tenure ends on a dropped request or on the final allowed write
                    if (!w_owner_req || w_last) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_ptr_next;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;
    assign bus.busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dff_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dff_write_arbiter
//  Description : Scoreboard testbench for dff_write_arbiter (N_REQ=4,
//                WIDTH=8, MAX_HOLD=4) with directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_write_arbiter;

    logic clk;
    logic reset;
    logic mon_en;
    int   checks;
    int   errors;

    logic [3:0] exp_gnt_q [$];
    logic [7:0] exp_q_q   [$];
    logic [3:0] prev_gnt;

    dff_write_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

    dff_write_arbiter #(
        .N_REQ    (4),
        .WIDTH    (8),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_q(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q_q.push_back(v);
    endtask

    // Monitor: new grants and write strobes are popped from the scoreboard
    initial prev_gnt = 4'b0000;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                if (exp_gnt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got %b expected none", bus.gnt);
                end else begin
                    chk("grant", {28'd0, bus.gnt}, {28'd0, exp_gnt_q.pop_front()});
                end
            end
            if (bus.q_valid === 1'b1) begin
                if (exp_q_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got q=%h expected none", bus.q);
                end else begin
                    chk("qdata", {24'd0, bus.q}, {24'd0, exp_q_q.pop_front()});
                end
                chk("write_inside_tenure", {31'd0, prev_gnt != 4'b0000}, 32'd1);
            end
            chk("busy", {31'd0, bus.busy}, {31'd0, bus.gnt != 4'b0000});
            prev_gnt = bus.gnt;
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b1;
        reset     = 1'b0;
        bus.req   = 4'b0000;
        bus.wdata = 32'd0;

        // 1: reset held with all requesting
        bus.req   = 4'b1111;
        bus.wdata = 32'h11223344;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t1_gnt",     {28'd0, bus.gnt}, 32'd0);
            chk("t1_q",       {24'd0, bus.q},   32'd0);
            chk("t1_q_valid", {31'd0, bus.q_valid}, 32'd0);
            chk("t1_busy",    {31'd0, bus.busy}, 32'd0);
        end

        // 2: requester 2 for three cycles -> grant + two writes
        reset     = 1'b1;
        bus.req   = 4'b0000;
        bus.wdata = 32'd0;
        step();
        exp_gnt_q.push_back(4'b0100);
        push_q(8'hA5, 2);
        bus.req          = 4'b0100;
        bus.wdata[23:16] = 8'hA5;
        step();
        chk("t2_gnt", {28'd0, bus.gnt}, 32'h4);
        step();
        step();
        bus.req = 4'b0000;
        step();
        chk("t2_release", {28'd0, bus.gnt}, 32'd0);
        chk("t2_q",       {24'd0, bus.q},   32'hA5);
        step();

        // 3: requester 0 alone for 12 cycles, data incrementing
        exp_gnt_q.push_back(4'b0001);
        exp_gnt_q.push_back(4'b0001);
        exp_gnt_q.push_back(4'b0001);
        push_q(8'h11, 1); push_q(8'h12, 1); push_q(8'h13, 1); push_q(8'h14, 1);
        push_q(8'h16, 1); push_q(8'h17, 1); push_q(8'h18, 1); push_q(8'h19, 1);
        push_q(8'h1B, 1);
        bus.wdata = 32'd0;
        for (int k = 0; k < 12; k++) begin
            bus.req         = 4'b0001;
            bus.wdata[7:0]  = 8'h10 + 8'(k);
            step();
            if (k == 4) chk("t3_gap",     {28'd0, bus.gnt}, 32'd0);
            if (k == 5) chk("t3_regrant", {28'd0, bus.gnt}, 32'h1);
        end
        bus.req = 4'b0000;
        step();
        step();

        // 4: all requesting from a freshly reset pointer
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_gnt_q.push_back(4'b0001);
        exp_gnt_q.push_back(4'b0010);
        exp_gnt_q.push_back(4'b0100);
        exp_gnt_q.push_back(4'b1000);
        exp_gnt_q.push_back(4'b0001);
        push_q(8'hC0, 4); push_q(8'hC1, 4); push_q(8'hC2, 4); push_q(8'hC3, 4);
        push_q(8'hC0, 4);
        bus.wdata = 32'hC3C2C1C0;
        bus.req   = 4'b1111;
        for (int k = 0; k < 25; k++) begin
            step();
            if (k == 9) chk("t4_idle_gap", {28'd0, bus.gnt}, 32'd0);
        end
        bus.req = 4'b0000;
        step();
        step();

        // 5: reset in the middle of requester 1's tenure
        exp_gnt_q.push_back(4'b0010);
        push_q(8'h5A, 2);
        bus.wdata[15:8] = 8'h5A;
        bus.req         = 4'b0010;
        step();
        step();
        step();
        reset   = 1'b0;
        bus.req = 4'b1111;
        step();
        chk("t5_gnt",     {28'd0, bus.gnt}, 32'd0);
        chk("t5_q",       {24'd0, bus.q},   32'd0);
        chk("t5_q_valid", {31'd0, bus.q_valid}, 32'd0);
        chk("t5_busy",    {31'd0, bus.busy}, 32'd0);
        reset = 1'b1;
        exp_gnt_q.push_back(4'b0001);
        step();
        chk("t5_first_after_reset", {28'd0, bus.gnt}, 32'h1);
        bus.req = 4'b0000;
        step();
        step();

        // 6: one write from requester 1, then a 1-cycle pulse on requester 3
        exp_gnt_q.push_back(4'b0010);
        push_q(8'h77, 1);
        bus.wdata[15:8] = 8'h77;
        bus.req         = 4'b0010;
        step();
        step();
        bus.req = 4'b0000;
        step();
        exp_gnt_q.push_back(4'b1000);
        bus.wdata[31:24] = 8'hEE;
        bus.req          = 4'b1000;
        step();
        chk("t6_pulse_gnt", {28'd0, bus.gnt}, 32'h8);
        bus.req = 4'b0000;
        step();
        chk("t6_end_gnt",   {28'd0, bus.gnt}, 32'd0);
        chk("t6_q_hold",    {24'd0, bus.q},   32'h77);
        chk("t6_no_write",  {31'd0, bus.q_valid}, 32'd0);
        exp_gnt_q.push_back(4'b0001);
        bus.req = 4'b1111;
        step();
        chk("t6_wrap_to_0", {28'd0, bus.gnt}, 32'h1);
        bus.req = 4'b0000;
        step();
        step();
        step();

        chk("grants_all_seen", exp_gnt_q.size(), 32'd0);
        chk("writes_all_seen", exp_q_q.size(),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
